// File: rtl/fourmux_arbiter_pkg.sv
// fourmux_arb_pkg: shared types, constants and the round-robin pick helper
// for the fourmux_arbiter block.
//   state_t  : IDLE (no word held) / FULL (word held, waiting on READY)
//   SEL_W    : mux select width
//   NREQ     : number of requesters
//   RR_RESET : rr_ptr reset value, so that requester 0 has first priority
//   rr_pick  : first requester with req set, searching ptr+1, ptr+2, ... mod 4
package fourmux_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam int unsigned SEL_W   = 2;
    localparam int unsigned NREQ    = 4;
    localparam logic [1:0]  RR_RESET = 2'd3;

    // Returns ptr itself when req is all-zero; callers only use the result
    // when |req is true.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NREQ-1:0]  req,
                                                  input logic [SEL_W-1:0] ptr);
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = ptr + k[SEL_W-1:0];
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/fourmux_arbiter_mux.sv
// fourmux_32: the existing 32-bit 4:1 data multiplexer.
//   A, B, C, D : data inputs for select 0..3
//   S          : select
//   Q          : selected word (combinational)
module fourmux_32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] C,
    input  logic [31:0] D,
    input  logic [1:0]  S,
    output logic [31:0] Q
);

    always_comb begin
        Q = A;
        case (S)
            2'd0: Q = A;
            2'd1: Q = B;
            2'd2: Q = C;
            2'd3: Q = D;
            default: Q = A;
        endcase
    end

endmodule

// File: rtl/fourmux_arbiter.sv
// fourmux_arbiter: round-robin arbiter that shares one fourmux_32 between
// four requesters and presents the captured word with VALID/READY.
// Optional build macro: ARB_LOCK_EN (per-requester burst lock via LOCK).
//   CLK, RST_N : clock (rising edge), asynchronous active-low reset
//   REQ        : per-requester pending flag, held until its ACK
//   A, B, C, D : requester 0..3 data, sampled only on the capture edge
//   ACK        : one-hot pulse, requester's word captured on this edge
//   S          : registered mux select of the current/last winner
//   Q          : registered output word
//   VALID      : Q holds an unconsumed word
//   READY      : consumer takes Q when VALID && READY at a rising edge
//   LOCK       : burst lock per requester (ignored without ARB_LOCK_EN)
module fourmux_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [NREQ-1:0]  REQ,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    output logic [NREQ-1:0]  ACK,
    output logic [1:0]       S,
    output logic [WIDTH-1:0] Q,
    output logic             VALID,
    input  logic             READY,
    input  logic [NREQ-1:0]  LOCK
);

    import fourmux_arb_pkg::*;

    state_t           state;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] winner;
    logic [SEL_W-1:0] s_next;
    logic [WIDTH-1:0] mux_q;
    logic             capture;

    // Reset gates the capture so no ACK is seen while RST_N is low.
    assign capture = RST_N && ((state == IDLE) || READY) && (|REQ);

`ifdef ARB_LOCK_EN
    // Distinguishes "rr_ptr holds a real last winner" from the reset value,
    // so a LOCK on requester 3 cannot steal the first grant after reset.
    logic last_vld;

    always_comb begin
        winner = rr_pick(REQ, rr_ptr);
        if (last_vld && LOCK[rr_ptr] && REQ[rr_ptr])
            winner = rr_ptr;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            last_vld <= 1'b0;
        else if (capture)
            last_vld <= 1'b1;
    end
`else
    logic unused_lock;
    assign unused_lock = ^LOCK;

    always_comb begin
        winner = rr_pick(REQ, rr_ptr);
    end
`endif

    assign s_next = capture ? winner : S;

    always_comb begin
        ACK = '0;
        if (capture)
            ACK[winner] = 1'b1;
    end

    fourmux_32 u_mux (
        .A (A),
        .B (B),
        .C (C),
        .D (D),
        .S (s_next),
        .Q (mux_q)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            rr_ptr <= RR_RESET;
            S      <= '0;
            Q      <= '0;
            VALID  <= 1'b0;
        end else if (capture) begin
            state  <= FULL;
            rr_ptr <= winner;
            S      <= winner;
            Q      <= mux_q;
            VALID  <= 1'b1;
        end else if (state == FULL && READY) begin
            state  <= IDLE;
            VALID  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fourmux_arbiter.sv
module tb_fourmux_arbiter;

    logic        CLK;
    logic        RST_N;
    logic [3:0]  REQ;
    logic [31:0] A, B, C, D;
    logic [3:0]  ACK;
    logic [1:0]  S;
    logic [31:0] Q;
    logic        VALID;
    logic        READY;
    logic [3:0]  LOCK;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] DA = 32'hAAAAAAAA;
    localparam logic [31:0] DB = 32'h55555555;
    localparam logic [31:0] DC = 32'h00000000;
    localparam logic [31:0] DD = 32'hFFFFFFFF;

    fourmux_arbiter #(.WIDTH(32), .NREQ(4)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .REQ   (REQ),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D),
        .ACK   (ACK),
        .S     (S),
        .Q     (Q),
        .VALID (VALID),
        .READY (READY),
        .LOCK  (LOCK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [3:0]  req;
        logic        ready;
        logic [3:0]  lock;
        logic [3:0]  ack;
        logic        valid;
        logic [1:0]  s;
        logic [31:0] q;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [3:0] req, input logic ready,
                       input logic [3:0] lock, input logic [3:0] ack, input logic valid,
                       input logic [1:0] s, input logic [31:0] q);
        vec_t v;
        v.name = name; v.req = req; v.ready = ready; v.lock = lock;
        v.ack = ack; v.valid = valid; v.s = s; v.q = q;
        vecs.push_back(v);
    endtask

    // Drive at negedge, check ACK before the edge, check registers after it.
    task automatic step(input vec_t v);
        @(negedge CLK);
        REQ   = v.req;
        READY = v.ready;
        LOCK  = v.lock;
        #1;
        chk({v.name, ".ack"}, {28'd0, ACK}, {28'd0, v.ack});
        @(posedge CLK);
        #1;
        chk({v.name, ".valid"}, {31'd0, VALID}, {31'd0, v.valid});
        chk({v.name, ".s"},     {30'd0, S},     {30'd0, v.s});
        chk({v.name, ".q"},     Q,              v.q);
    endtask

    initial begin
        RST_N = 1'b0; REQ = '0; READY = 1'b0; LOCK = '0;
        A = DA; B = DB; C = DC; D = DD;
        #1;
        chk("reset.valid", {31'd0, VALID}, 32'd0);
        chk("reset.q",     Q,              32'd0);
        chk("reset.s",     {30'd0, S},     32'd0);
        chk("reset.ack",   {28'd0, ACK},   32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        // Rotation, one word per cycle
        add("rot0", 4'b1111, 1'b1, 4'b0000, 4'b0001, 1'b1, 2'd0, DA);
        add("rot1", 4'b1111, 1'b1, 4'b0000, 4'b0010, 1'b1, 2'd1, DB);
        add("rot2", 4'b1111, 1'b1, 4'b0000, 4'b0100, 1'b1, 2'd2, DC);
        add("rot3", 4'b1111, 1'b1, 4'b0000, 4'b1000, 1'b1, 2'd3, DD);
        add("rot4", 4'b1111, 1'b1, 4'b0000, 4'b0001, 1'b1, 2'd0, DA);
        // Backpressure: held for 5 cycles, then B
        for (int i = 0; i < 5; i++)
            add("bp", 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, DA);
        add("bp_rel", 4'b1111, 1'b1, 4'b0000, 4'b0010, 1'b1, 2'd1, DB);
        add("drain",  4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd1, DB);
        add("idle",   4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd1, DB);
        // Sparse requests
        add("sp3",    4'b1000, 1'b0, 4'b0000, 4'b1000, 1'b1, 2'd3, DD);
        add("sp0",    4'b0001, 1'b1, 4'b0000, 4'b0001, 1'b1, 2'd0, DA);
        add("spdrn",  4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, DA);
        // Skip logic: bring rr_ptr to 1, then REQ=0011 wraps to 0
        add("skp1",   4'b0010, 1'b1, 4'b0000, 4'b0010, 1'b1, 2'd1, DB);
        add("skp0",   4'b0011, 1'b1, 4'b0000, 4'b0001, 1'b1, 2'd0, DA);
        // Single persistent requester wins every cycle
        for (int i = 0; i < 3; i++)
            add("pers2", 4'b0100, 1'b1, 4'b0000, 4'b0100, 1'b1, 2'd2, DC);
        add("pdrn",   4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2, DC);
        // Lock: rr_ptr=2 here, so requester 1 wins first either way
        add("lk0",    4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1, 2'd1, DB);
`ifdef ARB_LOCK_EN
        add("lk1",    4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1, 2'd1, DB);
        add("lk2",    4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1, 2'd1, DB);
        add("lk3",    4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1, 2'd1, DB);
        add("lkrel",  4'b1111, 1'b1, 4'b0000, 4'b0100, 1'b1, 2'd2, DC);
`else
        add("lk1",    4'b1111, 1'b1, 4'b0010, 4'b0100, 1'b1, 2'd2, DC);
        add("lk2",    4'b1111, 1'b1, 4'b0010, 4'b1000, 1'b1, 2'd3, DD);
        add("lk3",    4'b1111, 1'b1, 4'b0010, 4'b0001, 1'b1, 2'd0, DA);
        add("lkrel",  4'b1111, 1'b1, 4'b0000, 4'b0010, 1'b1, 2'd1, DB);
`endif
        add("lkdrn",  4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            // lkdrn keeps whatever S/Q the last lock capture left
            if (vecs[i].name == "lkdrn") begin
`ifdef ARB_LOCK_EN
                vecs[i].s = 2'd2; vecs[i].q = DC;
`else
                vecs[i].s = 2'd1; vecs[i].q = DB;
`endif
            end
            step(vecs[i]);
        end

        // Data sampled only on the capture edge
        @(negedge CLK);
        A = 32'h12345678; REQ = 4'b0001; READY = 1'b0; LOCK = '0;
        #1;
        chk("samp.ack", {28'd0, ACK}, 32'h1);
        @(posedge CLK); #1;
        chk("samp.q", Q, 32'h12345678);
        @(negedge CLK);
        A = 32'hDEADBEEF; REQ = 4'b0000;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("samp.hold.q", Q, 32'h12345678);
        chk("samp.hold.valid", {31'd0, VALID}, 32'd1);

        // Reset mid-FULL holding FFFFFFFF
        @(negedge CLK);
        REQ = 4'b1000; READY = 1'b1;
        @(posedge CLK); #1;
        chk("rst.pre.q", Q, DD);
        @(negedge CLK);
        READY = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        chk("rst.valid", {31'd0, VALID}, 32'd0);
        chk("rst.q",     Q,              32'd0);
        chk("rst.s",     {30'd0, S},     32'd0);
        chk("rst.ack",   {28'd0, ACK},   32'd0);
        @(posedge CLK); #1;
        chk("rst.hold.valid", {31'd0, VALID}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1; REQ = 4'b1111; READY = 1'b1;
        #1;
        chk("rst.first.ack", {28'd0, ACK}, 32'h1);
        @(posedge CLK); #1;
        chk("rst.first.q", Q, 32'hDEADBEEF);
        chk("rst.first.s", {30'd0, S}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
